// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that shares the write port of one FWFT FIFO
// (prog-full/count variant) between C_NUM_REQ producer streams. A requester
// owns the write port for a whole burst; the burst ends on req_last or after
// C_MAX_BURST beats. New bursts start only while fifo_prog_full is low. The
// arbiter also owns the FIFO threshold input, latched from cfg_thresh while
// idle so the FIFO sees a stable threshold for the duration of a burst.
//
// Build option:
//   FIFO_WR_ARB_PRIO0_EN  when defined, requester 0 has strict priority at
//                         arbitration; requesters 1..C_NUM_REQ-1 rotate via
//                         rr_ptr and a requester-0 grant leaves rr_ptr alone.
//                         When undefined, plain round-robin over all.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req_valid      per-requester beat valid
//   req_last       per-requester last beat of a burst
//   req_data       requester i data at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
//   req_ready      per-requester beat accept (only the owner, only if !full)
//   grant          one-hot burst owner, zero when idle (registered)
//   fifo_wren      FIFO write strobe
//   fifo_datain    FIFO write data (owner's data, combinational mux)
//   fifo_full      FIFO full flag, stalls the current burst
//   fifo_prog_full FIFO programmable-full flag, blocks new bursts
//   fifo_thresh    FIFO threshold input (registered)
//   cfg_thresh     requested threshold
//   busy           high while a burst is in progress (registered)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_NUM_REQ    = 4,
  parameter int C_MAX_BURST  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_NUM_REQ-1:0]              req_valid,
  input  logic [C_NUM_REQ-1:0]              req_last,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data,
  output logic [C_NUM_REQ-1:0]              req_ready,
  output logic [C_NUM_REQ-1:0]              grant,
  output logic                              fifo_wren,
  output logic [C_DATA_WIDTH-1:0]           fifo_datain,
  input  logic                              fifo_full,
  input  logic                              fifo_prog_full,
  output logic [31:0]                       fifo_thresh,
  input  logic [31:0]                       cfg_thresh,
  output logic                              busy
);

  localparam int IDX_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  // One extra bit so pointer + offset can exceed C_NUM_REQ before wrapping.
  localparam int SW = IDX_W + 1;
  localparam logic [SW-1:0] NUM_REQ_S = SW'(C_NUM_REQ);
  localparam logic [15:0]   LAST_CNT  = 16'(C_MAX_BURST - 1);

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gidx;       // index of the current owner
  logic [15:0]      beat_cnt;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [SW-1:0]    scan;
  logic [SW-1:0]    nxt_sum;
  logic             xfer;
  logic             beat;
  logic             burst_end;

  // ---------------------------------------------------------------------------
  // Arbitration: first valid requester scanning circularly from rr_ptr.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default on entry, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (req_valid[0]) begin
      pick_vld = 1'b1;
    end else begin
      // Rotation covers 1..C_NUM_REQ-1; a pointer of 0 (reset) starts at 1.
      for (int k = 0; k < C_NUM_REQ - 1; k++) begin
        scan = ((rr_ptr == '0) ? SW'(1) : {1'b0, rr_ptr}) + SW'(k);
        if (scan >= NUM_REQ_S) begin
          scan = scan - (NUM_REQ_S - SW'(1));
        end
        if (!pick_vld && req_valid[scan[IDX_W-1:0]]) begin
          pick_vld = 1'b1;
          pick_idx = scan[IDX_W-1:0];
        end
      end
    end
`else
    for (int k = 0; k < C_NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + SW'(k);
      if (scan >= NUM_REQ_S) begin
        scan = scan - NUM_REQ_S;
      end
      if (!pick_vld && req_valid[scan[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[IDX_W-1:0];
      end
    end
`endif
  end

  // Pointer value to load when the current burst ends: one past the owner.
  always_comb begin
    nxt_sum = {1'b0, gidx} + SW'(1);
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (gidx == '0) begin
      nxt_sum = {1'b0, rr_ptr};        // priority grants do not rotate
    end else if (nxt_sum == NUM_REQ_S) begin
      nxt_sum = SW'(1);
    end
`else
    if (nxt_sum == NUM_REQ_S) begin
      nxt_sum = '0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Write path. Decoded from registered state so reset clears it immediately;
  // fifo_full reaches req_ready with no register in between.
  // ---------------------------------------------------------------------------
  assign xfer      = (state == S_XFER);
  assign req_ready = (xfer && !fifo_full) ? grant : '0;
  assign beat      = |(req_valid & req_ready);
  assign burst_end = beat && ((|(req_last & grant)) || (beat_cnt == LAST_CNT));
  assign fifo_wren = beat;

  always_comb begin
    fifo_datain = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant[i]) begin
        fifo_datain = req_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered grant/busy/threshold.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      fifo_thresh <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fifo_thresh <= cfg_thresh;
          if (!fifo_prog_full && pick_vld) begin
            grant    <= C_NUM_REQ'(1) << pick_idx;
            gidx     <= pick_idx;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          // prog_full is ignored here: only fifo_full (via req_ready) stalls.
          if (beat) begin
            if (burst_end) begin
              grant    <= '0;
              busy     <= 1'b0;
              beat_cnt <= '0;
              rr_ptr   <= nxt_sum[IDX_W-1:0];
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (4 requesters, 32-bit data, 4-beat burst
// limit). Each requester is a small stream source whose data word is
// {requester id, sequence number}. Expected FIFO writes and expected grants
// are queued when a step is set up and popped as the DUT produces them.
// Outputs are sampled on the falling clock edge or 1 time unit after the
// rising edge; inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           fifo_wren;
  logic [W-1:0]   fifo_datain;
  logic           fifo_full      = 1'b0;
  logic           fifo_prog_full = 1'b0;
  logic [31:0]    fifo_thresh;
  logic [31:0]    cfg_thresh = 32'h100;
  logic           busy;

  fifo_wr_arbiter #(
    .C_DATA_WIDTH (W),
    .C_NUM_REQ    (N),
    .C_MAX_BURST  (MB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .grant          (grant),
    .fifo_wren      (fifo_wren),
    .fifo_datain    (fifo_datain),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .fifo_thresh    (fifo_thresh),
    .cfg_thresh     (cfg_thresh),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Source state per requester.
  int src_left [N];   // beats still to send (0 = not requesting)
  int src_seq  [N];   // next sequence number
  int src_blen [N];   // burst length signalled by req_last (0 = none)
  int src_bpos [N];   // position inside the current source burst

  // Scoreboard.
  logic [W-1:0] dq[$];    // expected FIFO write data, in order
  logic [N-1:0] gq[$];    // expected grants, in order
  int           blq[$];   // observed burst lengths

  int           n_total = 0;
  int           n_pass  = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           wr_cnt  = 0;
  int           cur_beats = 0;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int r, input int s);
    return {8'(r), 24'(s)};
  endfunction

  task automatic exp_data(input int r, input int s0, input int n);
    for (int k = 0; k < n; k++) dq.push_back(word(r, s0 + k));
  endtask

  task automatic src_clear();
    for (int i = 0; i < N; i++) begin
      src_left[i] = 0;
      src_seq[i]  = 0;
      src_blen[i] = 0;
      src_bpos[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (src_left[i] > 0);
      req_last[i]  = (src_left[i] == 1) ||
                     (src_blen[i] != 0 && src_bpos[i] == src_blen[i] - 1);
      req_data[i*W +: W] = word(i, src_seq[i]);
    end
  endtask

  // One clock: monitor at the falling edge, advance sources on accepted beats,
  // then drive new source outputs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fifo_full) begin
      check("stall_wren", fifo_wren, 0);
      check("stall_ready", req_ready, 0);
    end
    if (grant != prev_grant && grant != '0) begin
      if (gq.size() == 0) check("grant_unexpected", grant, 0);
      else check("grant", grant, gq.pop_front());
    end
    if (prev_grant != '0 && grant == '0) begin
      blq.push_back(cur_beats);
      cur_beats = 0;
    end
    prev_grant = grant;
    if (fifo_wren) begin
      wr_cnt++;
      cur_beats++;
      if (dq.size() == 0) check("wr_unexpected", fifo_wren, 0);
      else check("fifo_datain", fifo_datain, dq.pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        src_seq[i]++;
        src_left[i]--;
        if (src_blen[i] != 0 && src_bpos[i] == src_blen[i] - 1) src_bpos[i] = 0;
        else src_bpos[i]++;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (dq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", dq.size(), 0);
    for (int i = 0; i < N; i++) src_left[i] = 0;
    drive();
    tick();
    tick();
    check("grants_outstanding", gq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int exp_len [3];
    exp_len = '{4, 4, 2};

    // ---------------- reset state (requests pending during reset) ----------
    src_clear();
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wren", fifo_wren, 0);
    check("rst_thresh", fifo_thresh, 0);
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_thresh_latch", fifo_thresh, 32'h100);

    // ---------------- round-robin: 4 requesters, bursts of 3 ----------------
    src_clear();
    for (int i = 0; i < N; i++) begin
      src_blen[i] = 3;
      src_left[i] = 3;
    end
    src_left[0] = 6;
`ifdef FIFO_WR_ARB_PRIO0_EN
    gq.push_back(4'b0001); gq.push_back(4'b0001); gq.push_back(4'b0010);
    gq.push_back(4'b0100); gq.push_back(4'b1000);
    exp_data(0, 0, 6); exp_data(1, 0, 3); exp_data(2, 0, 3); exp_data(3, 0, 3);
`else
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    exp_data(0, 0, 3); exp_data(1, 0, 3); exp_data(2, 0, 3); exp_data(3, 0, 3);
    exp_data(0, 3, 3);
`endif
    drive();
    w0 = wr_cnt;
    repeat (17) tick();
    check("rr_writes_in_16", wr_cnt - w0, 12);
    drain(20);

    // ---------------- burst limit: requester 2, 10 beats, no req_last -------
    src_clear();
    blq.delete();
    src_left[2] = 10;
    gq.push_back(4'b0100); gq.push_back(4'b0100); gq.push_back(4'b0100);
    exp_data(2, 0, 10);
    drive();
    drain(40);
    check("limit_burst_count", blq.size(), 3);
    for (int i = 0; i < 3 && i < blq.size(); i++) check("limit_burst_len", blq[i], exp_len[i]);

    // ---------------- full stall mid-burst ----------------------------------
    src_clear();
    src_left[1] = 8;
    gq.push_back(4'b0010); gq.push_back(4'b0010);
    exp_data(1, 0, 8);
    drive();
    repeat (3) tick();
    fifo_full  = 1'b1;
    cfg_thresh = 32'h200;
    repeat (5) begin
      tick();
      check("stall_grant_held", grant, 4'b0010);
      check("stall_thresh_held", fifo_thresh, 32'h100);
    end
    fifo_full = 1'b0;
    drain(30);

    // ---------------- prog_full gating --------------------------------------
    src_clear();
    blq.delete();
    fifo_prog_full = 1'b1;
    src_left[3] = 4;
    gq.push_back(4'b1000);
    exp_data(3, 0, 4);
    drive();
    repeat (4) begin
      tick();
      check("pf_no_grant", grant, 0);
    end
    fifo_prog_full = 1'b0;
    tick();
    check("pf_grant_next_cycle", grant, 4'b1000);
    tick();
    fifo_prog_full = 1'b1;   // rises mid-burst, must not truncate it
    drain(20);
    check("pf_burst_count", blq.size(), 1);
    if (blq.size() > 0) check("pf_burst_len", blq[0], 4);
    fifo_prog_full = 1'b0;

    // ---------------- reset mid-burst ---------------------------------------
    // A one-beat burst from requester 2 first moves rr_ptr away from 0.
    src_clear();
    src_left[2] = 1;
    gq.push_back(4'b0100);
    exp_data(2, 0, 1);
    drive();
    drain(10);

    src_clear();
    src_left[1] = 5;
    gq.push_back(4'b0010);
    exp_data(1, 0, 2);
    drive();
    repeat (3) tick();
    check("pre_rst_wren", fifo_wren, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_wren", fifo_wren, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_thresh", fifo_thresh, 0);
    check("pre_rst_beats", dq.size(), 0);
    src_clear();
    drive();
    prev_grant = '0;
    cur_beats  = 0;
    cfg_thresh = 32'h300;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_thresh", fifo_thresh, 0);
    @(posedge clk);
    #1;
    check("post_rst_thresh_idle", fifo_thresh, 32'h300);

    src_clear();
    src_left[0] = 2;
    src_left[3] = 2;
    gq.push_back(4'b0001); gq.push_back(4'b1000);
    exp_data(0, 0, 2); exp_data(3, 0, 2);
    drive();
    drain(20);

    // ---------------- priority: requesters 0 and 1 ----------------------------
    src_clear();
    src_blen[0] = 2; src_left[0] = 6;
    src_blen[1] = 2; src_left[1] = 2;
`ifdef FIFO_WR_ARB_PRIO0_EN
    gq.push_back(4'b0001); gq.push_back(4'b0001); gq.push_back(4'b0001);
    gq.push_back(4'b0010);
    exp_data(0, 0, 6); exp_data(1, 0, 2);
`else
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0001);
    gq.push_back(4'b0001);
    exp_data(0, 0, 2); exp_data(1, 0, 2); exp_data(0, 2, 4);
`endif
    drive();
    drain(30);
    check("final_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
